serv_bus_responder: RTL

//   Wishbone-style responder (target) for the core's instruction and data buses. Serves both

---
 rtl/serv_bus_responder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/serv_bus_responder.sv
// Shared single-port word RAM answering the core's ibus and dbus: one access at a time,
// programmable wait states, byte-lane writes, registered read data and one-cycle acks.
module serv_bus_responder #(
    parameter int DEPTH       = 8192,
    parameter int AW          = $clog2(DEPTH),
    parameter int WAIT_STATES = 0,
    parameter bit DBUS_FIRST  = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack
);

    localparam int         WORDS = DEPTH / 4;
    localparam int         IW    = (AW > 2) ? (AW - 2) : 1;
    localparam logic [3:0] LP_WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_grant_d;
    logic        w_grant_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        w_access;
    logic        w_ibus_ack_nxt;
    logic        w_dbus_ack_nxt;
    logic        r_ibus_ack;
    logic        r_dbus_ack;
    logic [31:0] r_rdt;
    logic [31:0] w_adr;
    logic [IW-1:0] w_idx;
    logic        w_we;
    logic        w_unused_adr;

    logic [31:0] r_mem [0:WORDS-1];

    // The granted bus alone drives the RAM address; ibus never writes.
    assign w_adr = r_grant_d ? i_dbus_adr : i_ibus_adr;
    assign w_we  = r_grant_d & i_dbus_we;

    generate
        if (AW > 2) begin : g_idx
            assign w_idx = w_adr[AW-1:2];
        end else begin : g_idx_single
            assign w_idx = '0;
        end
    endgenerate

    // Bits above AW alias the memory; bits [1:0] select nothing in a word RAM.
    assign w_unused_adr = &{1'b0, w_adr[31:AW], w_adr[1:0]};

    // Next-state, grant, wait counter and ack decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant_d;
        w_cnt_nxt      = r_cnt;
        w_access       = 1'b0;
        w_ibus_ack_nxt = 1'b0;
        w_dbus_ack_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_ibus_cyc || i_dbus_cyc) begin
                    w_state_nxt = S_BUSY;
                    w_grant_nxt = i_dbus_cyc && (DBUS_FIRST || !i_ibus_cyc);
                    w_cnt_nxt   = LP_WS;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_access       = 1'b1;
                    w_state_nxt    = S_ACK;
                    w_ibus_ack_nxt = !r_grant_d;
                    w_dbus_ack_nxt = r_grant_d;
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Control registers and read-data register, synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_grant_d  <= 1'b0;
            r_cnt      <= 4'd0;
            r_ibus_ack <= 1'b0;
            r_dbus_ack <= 1'b0;
            r_rdt      <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant_d  <= w_grant_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ibus_ack <= w_ibus_ack_nxt;
            r_dbus_ack <= w_dbus_ack_nxt;
            if (w_access) begin
                r_rdt <= r_mem[w_idx];
            end else begin
                r_rdt <= r_rdt;
            end
        end
    end

    // Byte-lane RAM write; a reset at the access edge suppresses it.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_access && w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_dbus_sel[b]) begin
                    r_mem[w_idx][8*b +: 8] <= i_dbus_dat[8*b +: 8];
                end
            end
        end
    end

    assign o_ibus_rdt = r_rdt;
    assign o_dbus_rdt = r_rdt;
    assign o_ibus_ack = r_ibus_ack;
    assign o_dbus_ack = r_dbus_ack;

endmodule
